// File: rtl/countdown_seq.sv
// Staged countdown sequencer: walks a step index up or down, holding each stage
// for TICKS_PER_STEP cycles, with pause, abort, restart and a one-cycle done pulse.
module countdown_seq #(
    parameter int unsigned STEPS          = 4,
    parameter int unsigned TICKS_PER_STEP = 50_000_000,
    localparam int SW = $clog2(STEPS),
    localparam int CW = $clog2(64'(TICKS_PER_STEP) + 64'd1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_pause,
    input  logic             i_dir,
    output logic [SW-1:0]    o_step,
    output logic [STEPS-1:0] o_lamp,
    output logic             o_active,
    output logic             o_paused,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [SW-1:0]     r_step;
    logic [CW-1:0]     r_cnt;
    logic              r_dir;
    logic [STEPS-1:0]  r_lamp;
    logic              r_active;
    logic              r_paused;
    logic              r_done;

    state_t            w_state_nxt;
    logic [SW-1:0]     w_step_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_dir_nxt;
    logic              w_go;
    logic              w_last_tick;
    logic              w_final_step;
    logic              w_active_nxt;
    logic              w_paused_nxt;
    logic              w_done_nxt;
    logic [STEPS-1:0]  w_lamp_nxt;

    assign w_last_tick  = (r_cnt == CW'(TICKS_PER_STEP - 1));
    assign w_final_step = r_dir ? (r_step == '0) : (r_step == SW'(STEPS - 1));

    // A paused sequence that sees pause drop takes a normal tick on that edge,
    // so the pause costs exactly as many cycles as pause was high.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_go        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_go = i_start;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_go        = i_start;
            end
            S_RUN, S_PAUSED: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (i_start) begin
                    w_go = 1'b1;
                end else if (i_pause) begin
                    w_state_nxt = S_PAUSED;
                end else begin
                    w_state_nxt = S_RUN;
                    if (w_last_tick) begin
                        w_cnt_nxt = '0;
                        if (w_final_step) begin
                            w_state_nxt = S_DONE;
                        end else if (r_dir) begin
                            w_step_nxt = r_step - SW'(1);
                        end else begin
                            w_step_nxt = r_step + SW'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_go) begin
            w_state_nxt = S_RUN;
            w_step_nxt  = i_dir ? SW'(STEPS - 1) : '0;
            w_cnt_nxt   = '0;
            w_dir_nxt   = i_dir;
        end
    end

    assign w_active_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSED);
    assign w_paused_nxt = (w_state_nxt == S_PAUSED);
    assign w_done_nxt   = (w_state_nxt == S_DONE);
    assign w_lamp_nxt   = w_active_nxt ? (STEPS'(1) << w_step_nxt) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_lamp   <= '0;
            r_active <= 1'b0;
            r_paused <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir    <= w_dir_nxt;
            r_lamp   <= w_lamp_nxt;
            r_active <= w_active_nxt;
            r_paused <= w_paused_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_step   = r_step;
    assign o_lamp   = r_lamp;
    assign o_active = r_active;
    assign o_paused = r_paused;
    assign o_done   = r_done;

endmodule

// File: tb/tb_countdown_seq.sv
// Bench for countdown_seq (STEPS=4, TICKS_PER_STEP=3): directed scenarios plus
// random traffic, all outputs compared every cycle against an elapsed-tick model.
module tb_countdown_seq;

    localparam int ST = 4;
    localparam int TK = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_pause = 1'b0;
    logic          i_dir   = 1'b0;
    logic [1:0]    o_step;
    logic [ST-1:0] o_lamp;
    logic          o_active;
    logic          o_paused;
    logic          o_done;

    int errors = 0;
    int checks = 0;

    countdown_seq #(.STEPS(ST), .TICKS_PER_STEP(TK)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_pause  (i_pause),
        .i_dir    (i_dir),
        .o_step   (o_step),
        .o_lamp   (o_lamp),
        .o_active (o_active),
        .o_paused (o_paused),
        .o_done   (o_done)
    );

    always #5 clk = ~clk;

    // Reference model: a sequence is just "how many run ticks have elapsed".
    bit m_active, m_paused, m_done, m_dir;
    int m_el, m_step;

    function automatic int stage_of(input int el, input bit d);
        return d ? (ST - 1 - el / TK) : (el / TK);
    endfunction

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_done = 0; m_dir = 0; m_el = 0; m_step = 0;
    endtask

    task automatic model_restart(input bit d);
        m_active = 1; m_paused = 0; m_done = 0; m_el = 0; m_dir = d;
        m_step = stage_of(0, d);
    endtask

    task automatic model_edge(input bit s, input bit a, input bit p, input bit d);
        if (m_active) begin
            if (a) begin
                m_active = 0; m_paused = 0; m_step = 0; m_done = 0;
            end else if (s) begin
                model_restart(d);
            end else if (p) begin
                m_paused = 1;
            end else begin
                m_paused = 0;
                m_el++;
                if (m_el == ST * TK) begin
                    m_active = 0; m_done = 1;
                end else begin
                    m_step = stage_of(m_el, m_dir);
                end
            end
        end else begin
            m_done = 0;
            if (s) model_restart(d);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("step",   32'(o_step),   32'(m_step));
        check("lamp",   32'(o_lamp),   m_active ? (32'd1 << m_step) : 32'd0);
        check("active", 32'(o_active), 32'(m_active));
        check("paused", 32'(o_paused), 32'(m_paused));
        check("done",   32'(o_done),   32'(m_done));
    endtask

    task automatic tick(input bit s, input bit a, input bit p, input bit d);
        @(negedge clk);
        i_start = s; i_abort = a; i_pause = p; i_dir = d;
        @(posedge clk);
        model_edge(s, a, p, d);
        #1 compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int done_at;
    int done_cnt;
    int paused_cnt;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        rst = 1'b0;

        // Ascending sequence
        tick(1, 0, 0, 0);
        check("up_first_lamp", 32'(o_lamp), 32'b0001);
        done_at = -1; done_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            tick(0, 0, 0, 0);
            if (i == 11) check("up_last_lamp", 32'(o_lamp), 32'b1000);
            if (o_done) begin done_at = i; done_cnt++; end
        end
        check("up_done_at", 32'(done_at), 32'd12);
        check("up_done_cnt", 32'(done_cnt), 32'd1);

        // Descending sequence
        tick(1, 0, 0, 1);
        check("dn_first_step", 32'(o_step), 32'd3);
        done_at = -1;
        for (int i = 1; i <= 14; i++) begin
            tick(0, 0, 0, 0);
            if (o_done) done_at = i;
        end
        check("dn_done_at", 32'(done_at), 32'd12);

        // Pause five cycles during step 1
        tick(1, 0, 0, 0);
        done_at = -1; paused_cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            tick(0, 0, (i >= 4 && i <= 8), 0);
            if (i == 4) check("pause_step", 32'(o_step), 32'd1);
            if (o_paused) paused_cnt++;
            if (o_done) done_at = i;
        end
        check("pause_cycles", 32'(paused_cnt), 32'd5);
        check("pause_done_at", 32'(done_at), 32'd17);

        // Abort during step 2, then restart
        tick(1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) tick(0, 0, 0, 0);
        check("abort_pre_step", 32'(o_step), 32'd2);
        tick(0, 1, 0, 0);
        check("abort_active", 32'(o_active), 32'd0);
        check("abort_lamp", 32'(o_lamp), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, 0);
            if (o_done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        tick(1, 0, 0, 0);
        check("abort_restart_step", 32'(o_step), 32'd0);

        // Start+abort together in RUN; start+pause together in IDLE
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 1);
        check("start_abort_active", 32'(o_active), 32'd0);
        tick(1, 0, 1, 0);
        check("start_pause_active", 32'(o_active), 32'd1);
        check("start_pause_step", 32'(o_step), 32'd0);
        tick(0, 0, 1, 0);
        tick(0, 1, 0, 0);

        // Asynchronous reset during step 3
        tick(1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) tick(0, 0, 0, 0);
        check("rst_pre_step", 32'(o_step), 32'd3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 rst = 1'b0;
        tick(1, 0, 0, 0);
        done_at = -1;
        for (int i = 1; i <= 14; i++) begin
            tick(0, 0, 0, 0);
            if (o_done) done_at = i;
        end
        check("rst_restart_done_at", 32'(done_at), 32'd12);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
